// File: rtl/video_effect_stream_if.sv
// Pixel stream bundle for video_effect_stream.
// Carries the input handshake (in_data/in_valid/in_ready) and the output
// handshake with frame tags (out_data/out_valid/out_ready/out_sop/out_eop).
//   slave  : the effect block's view (consumes input side, produces output side)
//   master : the surrounding source/sink view
interface video_effect_stream_if #(
  parameter int unsigned CW = 10
);
  logic [3*CW-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic [3*CW-1:0] out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_sop;
  logic            out_eop;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sop, out_eop
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sop, out_eop
  );
endinterface

// File: rtl/video_effect_stream.sv
// Per-frame colour effect on an {R,G,B} pixel stream.
// Two register stages: S1 holds the effected pixel, S2 drives the output.
// Effect mode and tint gain are captured on the (0,0) transfer and held for
// the whole frame.
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high
//   resync      synchronous frame restart (clears position and pipeline)
//   bus         pixel stream (in_* handshake, out_* handshake + sop/eop)
//   mode_req    requested effect: 0 pass, 1 gray, 2 tint, 3 invert
//   gain        tint gain in 1/64 units, clamped to [GAIN_MIN, GAIN_MAX]
//   active_mode effect applied to the current frame
//   frame_count completed input frames, wrapping at 16 bits
module video_effect_stream #(
  parameter int unsigned CW       = 10,
  parameter int unsigned H_RES    = 320,
  parameter int unsigned V_RES    = 240,
  parameter int unsigned GW       = 9,
  parameter int unsigned GAIN_MIN = 10,
  parameter int unsigned GAIN_MAX = 63
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  resync,
  video_effect_stream_if.slave  bus,
  input  logic [1:0]            mode_req,
  input  logic [GW-1:0]         gain,
  output logic [1:0]            active_mode,
  output logic [15:0]           frame_count
);
  localparam int unsigned COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int unsigned YW    = CW + 10;
  localparam int unsigned PW    = CW + 8;
  localparam int unsigned MW    = PW + GW;
  localparam int unsigned MAXC  = (2 ** CW) - 1;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_GRAY   = 2'd1,
    MODE_TINT   = 2'd2,
    MODE_INVERT = 2'd3
  } mode_t;

  mode_t           frame_mode, px_mode;
  logic [GW-1:0]   frame_gain, gain_clamped, px_gain;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic            at_sop, at_eop, in_xfer;
  logic            s1_valid, s2_valid, s1_adv, s2_adv;
  logic [3*CW-1:0] fx_data, s1_data, s2_data;
  logic            s1_sop, s1_eop, s2_sop, s2_eop;
  logic [CW-1:0]   r, g, b, y, t;
  logic [YW-1:0]   y_sum, y_shr;
  logic [PW-1:0]   p;
  logic [MW-1:0]   prod, t_shr;

  assign {r, g, b} = bus.in_data;

  assign s2_adv       = !s2_valid || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;
  assign in_xfer      = bus.in_valid && s1_adv;

  assign at_sop = (col == '0) && (row == '0);
  assign at_eop = (col == COL_W'(H_RES - 1)) && (row == ROW_W'(V_RES - 1));

  always_comb begin
    gain_clamped = gain;
    if (gain < GW'(GAIN_MIN))
      gain_clamped = GW'(GAIN_MIN);
    else if (gain > GW'(GAIN_MAX))
      gain_clamped = GW'(GAIN_MAX);
  end

  // The (0,0) pixel already uses the settings it samples.
  assign px_mode = at_sop ? mode_t'(mode_req) : frame_mode;
  assign px_gain = at_sop ? gain_clamped : frame_gain;

  always_comb begin
    y_sum = YW'(77) * YW'(r) + YW'(150) * YW'(g) + YW'(29) * YW'(b);
    y_shr = y_sum >> 8;
    y     = (y_shr > YW'(MAXC)) ? '1 : y_shr[CW-1:0];
    p     = PW'(120) * PW'(r) + PW'(60) * PW'(g) + PW'(50) * PW'(b);
    prod  = MW'(p) * MW'(px_gain);
    t_shr = prod >> 14;
    t     = (t_shr > MW'(MAXC)) ? '1 : t_shr[CW-1:0];
    fx_data = '0;
    case (px_mode)
      MODE_PASS:   fx_data = bus.in_data;
      MODE_GRAY:   fx_data = {y, y, y};
      MODE_TINT:   fx_data = {t, t >> 2, t >> 1};
      MODE_INVERT: fx_data = {CW'(MAXC) - r, CW'(MAXC) - g, CW'(MAXC) - b};
      default:     fx_data = bus.in_data;
    endcase
  end

  // Frame position, per-frame settings and frame counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col         <= '0;
      row         <= '0;
      frame_mode  <= MODE_PASS;
      frame_gain  <= '0;
      frame_count <= '0;
    end else if (resync) begin
      col <= '0;
      row <= '0;
    end else if (in_xfer) begin
      if (col == COL_W'(H_RES - 1)) begin
        col <= '0;
        if (row == ROW_W'(V_RES - 1))
          row <= '0;
        else
          row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
      if (at_sop) begin
        frame_mode <= mode_t'(mode_req);
        frame_gain <= gain_clamped;
      end
      if (at_eop)
        frame_count <= frame_count + 16'd1;
    end
  end

  // Two-stage elastic pipeline; each stage loads when empty or draining.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_sop   <= 1'b0;
      s1_eop   <= 1'b0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_sop   <= 1'b0;
      s2_eop   <= 1'b0;
    end else if (resync) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_xfer;
        if (in_xfer) begin
          s1_data <= fx_data;
          s1_sop  <= at_sop;
          s1_eop  <= at_eop;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= s1_data;
          s2_sop  <= s1_sop;
          s2_eop  <= s1_eop;
        end
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.out_sop   = s2_sop;
  assign bus.out_eop   = s2_eop;
  assign active_mode   = frame_mode;
endmodule

// File: tb/tb_video_effect_stream.sv
// Directed bench for video_effect_stream with 4x2 frames.
module tb_video_effect_stream;
  localparam int unsigned CW    = 10;
  localparam int unsigned H_RES = 4;
  localparam int unsigned V_RES = 2;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        resync   = 1'b0;
  logic [1:0]  mode_req = 2'd0;
  logic [8:0]  gain     = 9'd0;
  logic [1:0]  active_mode;
  logic [15:0] frame_count;

  int vectors     = 0;
  int miscompares = 0;

  video_effect_stream_if #(.CW(CW)) bus ();

  video_effect_stream #(
    .CW(CW), .H_RES(H_RES), .V_RES(V_RES), .GW(9), .GAIN_MIN(10), .GAIN_MAX(63)
  ) dut (
    .clk(clk),
    .reset(reset),
    .resync(resync),
    .bus(bus),
    .mode_req(mode_req),
    .gain(gain),
    .active_mode(active_mode),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] pix(input int unsigned r, input int unsigned g, input int unsigned b);
    return {10'(r), 10'(g), 10'(b)};
  endfunction

  function automatic logic [29:0] inv(input logic [29:0] d);
    return {10'd1023 - d[29:20], 10'd1023 - d[19:10], 10'd1023 - d[9:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned n_in, n_out, fc_exp, j;
    logic [29:0] expq[$];
    logic [29:0] exp_px, prev_data;
    logic prev_stall;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    fc_exp = 0;

    // Reset state
    step();
    step();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_sop", bus.out_sop, 0);
    chk("rst_out_eop", bus.out_eop, 0);
    chk("rst_active_mode", active_mode, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    reset = 1'b0;
    step();

    // Gray, two-cycle latency, mode held for the frame
    mode_req = 2'd1;
    bus.in_valid = 1'b1;
    bus.in_data = pix(1023, 1023, 1023);
    step();
    mode_req = 2'd0;
    bus.in_data = pix(100, 200, 50);
    chk("gray_lat1_valid", bus.out_valid, 0);
    chk("gray_active_mode", active_mode, 1);
    step();
    bus.in_valid = 1'b0;
    chk("gray_lat2_valid", bus.out_valid, 1);
    chk("gray_white", bus.out_data, pix(1023, 1023, 1023));
    chk("gray_sop", bus.out_sop, 1);
    step();
    chk("gray_mixed", bus.out_data, pix(152, 152, 152));
    chk("gray_sop2", bus.out_sop, 0);
    step();
    chk("gray_drained", bus.out_valid, 0);
    resync = 1'b1;
    step();
    resync = 1'b0;
    chk("resync1_fc", frame_count, 0);
    chk("resync1_mode", active_mode, 1);

    // Tint with gain clamped high, then clamped low
    mode_req = 2'd2;
    gain = 9'd200;
    bus.in_valid = 1'b1;
    bus.in_data = pix(1023, 0, 0);
    step();
    gain = 9'd0;
    bus.in_data = pix(0, 1023, 0);
    step();
    bus.in_valid = 1'b0;
    chk("tint_hi_red", bus.out_data, pix(472, 118, 236));
    chk("tint_mode", active_mode, 2);
    step();
    chk("tint_hi_green", bus.out_data, pix(236, 59, 118));
    resync = 1'b1;
    step();
    resync = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = pix(1023, 0, 0);
    step();
    bus.in_valid = 1'b0;
    step();
    chk("tint_lo_red", bus.out_data, pix(74, 18, 37));

    // Full 4x2 frame, mode request changes at (2,0), next frame inverted
    resync = 1'b1;
    step();
    resync = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = pix(i * 10 + 1, i * 20 + 2, i * 30 + 3);
      mode_req = (i >= 2) ? 2'd3 : 2'd0;
      step();
      if (i >= 1) begin
        j = i - 1;
        exp_px = (j == 8) ? pix(942, 861, 780) : pix(j * 10 + 1, j * 20 + 2, j * 30 + 3);
        chk("frame_valid", bus.out_valid, 1);
        chk("frame_data", bus.out_data, exp_px);
        chk("frame_sop", bus.out_sop, (j == 0 || j == 8) ? 1 : 0);
        chk("frame_eop", bus.out_eop, (j == 7) ? 1 : 0);
      end
      if (i == 6) chk("frame_fc_before", frame_count, 0);
      if (i == 7) chk("frame_fc_after", frame_count, 1);
      if (i == 7) chk("frame_mode_held", active_mode, 0);
      if (i == 8) chk("frame_mode_new", active_mode, 3);
    end
    bus.in_valid = 1'b0;
    step();
    chk("frame_inv_last", bus.out_data, pix(932, 841, 750));
    fc_exp = 1;

    // Random backpressure with a continuous inverted stream
    resync = 1'b1;
    step();
    resync = 1'b0;
    mode_req = 2'd3;
    n_in = 0;
    n_out = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    for (int c = 0; c < 80; c++) begin
      bus.in_valid = (c < 60);
      bus.in_data = pix((n_in * 3) % 1024, (n_in * 5 + 7) % 1024, (n_in * 11 + 100) % 1024);
      bus.out_ready = (c < 60) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (bus.out_valid && prev_stall)
        chk("stall_hold", bus.out_data, prev_data);
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          chk("stream_extra", 1, 0);
        end else begin
          chk("stream_data", bus.out_data, expq.pop_front());
          chk("stream_sop", bus.out_sop, (n_out % 8 == 0) ? 1 : 0);
          chk("stream_eop", bus.out_eop, (n_out % 8 == 7) ? 1 : 0);
        end
        n_out++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(inv(bus.in_data));
        n_in++;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("stream_count", n_out, n_in);
    fc_exp = fc_exp + n_in / 8;
    chk("stream_fc", frame_count, fc_exp);

    // Resync with the (1,1) pixel pending
    resync = 1'b1;
    step();
    resync = 1'b0;
    mode_req = 2'd0;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = pix(i + 1, 0, 0);
      step();
    end
    bus.in_data = pix(500, 500, 500);
    resync = 1'b1;
    step();
    resync = 1'b0;
    bus.in_valid = 1'b0;
    chk("resync_empty", bus.out_valid, 0);
    chk("resync_in_ready", bus.in_ready, 1);
    chk("resync_fc", frame_count, fc_exp);
    step();
    chk("resync_still_empty", bus.out_valid, 0);
    bus.in_valid = 1'b1;
    bus.in_data = pix(7, 8, 9);
    step();
    bus.in_valid = 1'b0;
    step();
    chk("resync_sop", bus.out_sop, 1);
    chk("resync_data", bus.out_data, pix(7, 8, 9));
    chk("resync_mode", active_mode, 0);

    // Asynchronous reset mid-frame, then restart at (0,0)
    mode_req = 2'd3;
    bus.in_valid = 1'b1;
    bus.in_data = pix(9, 9, 9);
    step();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_fc", frame_count, 0);
    chk("mid_rst_mode", active_mode, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    step();
    reset = 1'b0;
    step();
    bus.in_valid = 1'b1;
    bus.in_data = pix(1, 2, 3);
    step();
    bus.in_valid = 1'b0;
    step();
    chk("mid_rst_sop", bus.out_sop, 1);
    chk("mid_rst_data", bus.out_data, pix(1022, 1021, 1020));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
